bus_arbiter_rr: RTL
===================

# bus_arbiter_rr

Parametrised N-master / M-slave arbiter for the serial-address bus, generalising the fixed two-master, three-slave arbiter. It grants the shared bus round-robin, deserialises a SLAVE_ADDR_BITS-wide slave address from the granted master, and routes that master's serial data, valid and write-enable to the addressed slave. It routes the slave's data, valid and ready back to the master. It adds decode-error reporting, request abort during addressing and fair rotation; it sits between the master ports and slave ports of the bus top level.

## Interface
- NUM_MASTERS, 2, number of masters (2..8)
- NUM_SLAVES, 3, number of slaves (1..2**SLAVE_ADDR_BITS)
- SLAVE_ADDR_BITS, 2, serial slave-address length, MSB first
- MW: derived, max(1, clog2(NUM_MASTERS)); SW: derived, max(1, clog2(NUM_SLAVES))
- clk  in  1  bus clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- m_request, m_address_valid, m_address, m_data, m_valid, m_write_en  in  NUM_MASTERS each  per-master bus request, address-start strobe, serial address bit, serial data bit, bit-valid, write enable
- m_grant  out  NUM_MASTERS  one-hot registered grant (replaces mX_available)
- m_ready, m_data_out, m_valid_in  out  NUM_MASTERS each  routed slave ready, read data bit, read valid (0 for ungranted masters)
- s_address, s_data, s_valid, s_write_en  out  NUM_SLAVES each  routed master signals (0 for unselected slaves)
- s_ready, s_data_in, s_valid_out  in  NUM_SLAVES each  slave handshake and read data
- state  out  2  FSM state (IDLE=0, ADDR=1, CONNECT=2, BUSY=3)
- grant_idx  out  MW  index of granted master; slave_sel  out  SW  selected slave index
- connected  out  1  a master-to-slave path is established
- decode_error  out  1  one-cycle pulse on an out-of-range address

## Operation
- IDLE: candidates are masters with m_request & m_address_valid both high. Priority search starts at rr_ptr and wraps. The winner is loaded into grant_idx, m_grant is set, bit counter and addr_buf are cleared, and the FSM goes to ADDR. With no candidate, the FSM stays in IDLE with m_grant=0.
- ADDR: each cycle the granted m_valid=1, addr_buf <= {addr_buf, m_address[g]} and the counter increments. After SLAVE_ADDR_BITS accepted bits the FSM goes to CONNECT. Cycles with m_valid=0 stall without a timeout. If m_request[g] drops, the FSM aborts to IDLE.
- CONNECT: if addr_buf < NUM_SLAVES, slave_sel <= addr_buf, connected <= 1, go to BUSY. Otherwise decode_error pulses, connected <= 0, go to IDLE.
- BUSY: granted master is routed to slave_sel.
  - m_request[g]=0: go to IDLE.
  - Otherwise m_address_valid[g]=1: re-address via ADDR, keeping the grant.
  - Request drop has priority over re-address.
- On every IDLE entry from ADDR/CONNECT/BUSY: rr_ptr <= grant_idx+1 (wrapping at NUM_MASTERS), m_grant <= 0, connected <= 0.
- Routing is active only while connected=1. During ADDR re-address the old path stays, but every s_valid is forced to 0. All non-routed outputs are 0.
- Reset values: state IDLE, m_grant 0, grant_idx 0, slave_sel 0, rr_ptr 0, connected 0, decode_error 0, addr_buf 0, counter 0. All routed outputs are therefore 0.

## Timing
- Request to grant: m_grant is visible one cycle after the IDLE sample.
- Minimum request to connected: 1 (grant) + SLAVE_ADDR_BITS (address) + 1 (CONNECT) edges. Default: 4 edges.
- Routing muxes are combinational from registered connected/slave_sel/grant_idx; zero-cycle forward and return paths.
- Simultaneous requests resolve in a single cycle by rr_ptr order. Losers hold their request and are served in rotation.
- Reset asserted mid-transfer clears all state immediately and asynchronously. The first grant after release needs a fresh IDLE sample.
- decode_error is high for exactly the cycle in which state==CONNECT with an invalid address.

## Test plan
- Reset, then m_request[0]=1 + address_valid, serial address 1,0 (value 2) -> m_grant=01 after 1 cycle; state ADDR, then CONNECT, then BUSY; slave_sel=2, connected=1; s_data[2] follows m_data[0]; all other s_* stay 0.
- Masters 0 and 1 request together from reset (rr_ptr=0) -> master 0 is granted first. After master 0 releases, with both still requesting, master 1 is granted; rotation is then 0,1,0.
- NUM_SLAVES=3, address 1,1 (value 3) -> decode_error=1 for one cycle, state returns to IDLE, connected=0, rr_ptr advances.
- m_request[g] dropped after the first address bit -> IDLE next cycle; m_grant=0; no slave output is ever active.
- In BUSY on slave 1, master pulses address_valid with new address 0,0 -> s_valid forced 0 during ADDR; then slave_sel=0 and traffic continues without a grant gap.
- reset pulsed high mid-BUSY for less than one clock period -> all outputs 0 immediately; state IDLE; rr_ptr 0.

Source files
------------

// File: rtl/bus_arbiter_rr.sv
// bus_arbiter_rr: round-robin N-master/M-slave arbiter for the serial-address bus
// clk/reset: bus clock, async active-high reset
// m_*: per-master request/address/data in; grant, routed ready/read data/read valid out
// s_*: routed master address/data/valid/write-enable out; slave ready/read data/read valid in
// state/grant_idx/slave_sel/connected/decode_error: arbiter status
module bus_arbiter_rr #(
  parameter int NUM_MASTERS = 2,
  parameter int NUM_SLAVES = 3,
  parameter int SLAVE_ADDR_BITS = 2,
  localparam int MW = NUM_MASTERS > 1 ? $clog2(NUM_MASTERS) : 1,
  localparam int SW = NUM_SLAVES > 1 ? $clog2(NUM_SLAVES) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_MASTERS-1:0] m_request,
  input  logic [NUM_MASTERS-1:0] m_address_valid,
  input  logic [NUM_MASTERS-1:0] m_address,
  input  logic [NUM_MASTERS-1:0] m_data,
  input  logic [NUM_MASTERS-1:0] m_valid,
  input  logic [NUM_MASTERS-1:0] m_write_en,
  output logic [NUM_MASTERS-1:0] m_grant,
  output logic [NUM_MASTERS-1:0] m_ready,
  output logic [NUM_MASTERS-1:0] m_data_out,
  output logic [NUM_MASTERS-1:0] m_valid_in,
  output logic [NUM_SLAVES-1:0]  s_address,
  output logic [NUM_SLAVES-1:0]  s_data,
  output logic [NUM_SLAVES-1:0]  s_valid,
  output logic [NUM_SLAVES-1:0]  s_write_en,
  input  logic [NUM_SLAVES-1:0]  s_ready,
  input  logic [NUM_SLAVES-1:0]  s_data_in,
  input  logic [NUM_SLAVES-1:0]  s_valid_out,
  output logic [1:0]             state,
  output logic [MW-1:0]          grant_idx,
  output logic [SW-1:0]          slave_sel,
  output logic                   connected,
  output logic                   decode_error
);
  localparam int CW = $clog2(SLAVE_ADDR_BITS + 1);
  typedef enum logic [1:0] {IDLE, ADDR, CONNECT, BUSY} state_t;
  state_t st;
  logic [MW-1:0] rr_ptr, win, nxt_ptr;
  logic [SLAVE_ADDR_BITS-1:0] addr_buf;
  logic [CW-1:0] cnt;
  logic [2*NUM_MASTERS-1:0] rot;
  logic found, valid_addr;
  int off;
  assign state = st;
  // candidates rotated so bit 0 is the master at rr_ptr; lowest set bit wins
  assign rot = {m_request & m_address_valid, m_request & m_address_valid} >> rr_ptr;
  always_comb begin
    found = 1'b0;
    off = 0;
    for (int k = NUM_MASTERS - 1; k >= 0; k--)
      if (rot[k]) begin
        found = 1'b1;
        off = k;
      end
    win = MW'((int'(rr_ptr) + off) % NUM_MASTERS);
  end
  assign nxt_ptr = grant_idx == MW'(NUM_MASTERS - 1) ? '0 : grant_idx + 1'b1;
  assign valid_addr = {1'b0, addr_buf} < (SLAVE_ADDR_BITS + 1)'(NUM_SLAVES);
  assign decode_error = st == CONNECT && !valid_addr;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      st <= IDLE;
      m_grant <= '0;
      grant_idx <= '0;
      slave_sel <= '0;
      rr_ptr <= '0;
      connected <= 1'b0;
      addr_buf <= '0;
      cnt <= '0;
    end else
      case (st)
        IDLE: if (found) begin
          grant_idx <= win;
          m_grant <= NUM_MASTERS'(1) << win;
          cnt <= '0;
          addr_buf <= '0;
          st <= ADDR;
        end
        ADDR: if (!m_request[grant_idx]) begin
          st <= IDLE;
          rr_ptr <= nxt_ptr;
          m_grant <= '0;
          connected <= 1'b0;
        end else if (m_valid[grant_idx]) begin
          addr_buf <= SLAVE_ADDR_BITS'({addr_buf, m_address[grant_idx]});
          cnt <= cnt + 1'b1;
          if (cnt == CW'(SLAVE_ADDR_BITS - 1)) st <= CONNECT;
        end
        CONNECT: if (valid_addr) begin
          slave_sel <= SW'(addr_buf);
          connected <= 1'b1;
          st <= BUSY;
        end else begin
          st <= IDLE;
          rr_ptr <= nxt_ptr;
          m_grant <= '0;
          connected <= 1'b0;
        end
        BUSY: if (!m_request[grant_idx]) begin
          st <= IDLE;
          rr_ptr <= nxt_ptr;
          m_grant <= '0;
          connected <= 1'b0;
        end else if (m_address_valid[grant_idx]) begin
          // re-address keeps the grant and the old path until CONNECT
          st <= ADDR;
          cnt <= '0;
          addr_buf <= '0;
        end
      endcase
  for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_m
    assign m_ready[i] = connected && grant_idx == MW'(i) && s_ready[slave_sel];
    assign m_data_out[i] = connected && grant_idx == MW'(i) && s_data_in[slave_sel];
    assign m_valid_in[i] = connected && grant_idx == MW'(i) && s_valid_out[slave_sel];
  end
  for (genvar j = 0; j < NUM_SLAVES; j++) begin : g_s
    assign s_address[j] = connected && slave_sel == SW'(j) && m_address[grant_idx];
    assign s_data[j] = connected && slave_sel == SW'(j) && m_data[grant_idx];
    assign s_write_en[j] = connected && slave_sel == SW'(j) && m_write_en[grant_idx];
    // address bits must not look like data to the old slave while re-addressing
    assign s_valid[j] = connected && slave_sel == SW'(j) && st != ADDR && m_valid[grant_idx];
  end
endmodule
